// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory responders (data side and instruction-side loader).
// Holds the common sequencing states and the CPU bus address range helper.
package cpu_mem_pkg;

    localparam int unsigned CPU_ADDR_W = 16;
    localparam int unsigned BYTE_W     = 8;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DUMP = 2'd2,
        ST_DONE = 2'd3
    } mem_state_t;

    // Any address bit at or above the array width makes the access out of range.
    function automatic logic addr_in_range(input logic [CPU_ADDR_W-1:0] a,
                                           input int unsigned depth_log2);
        return (a >> depth_log2) == '0;
    endfunction

endpackage

// File: rtl/data_ram_responder_if.sv
// Bus bundle between the data RAM responder, the CPU data port and the host
// preload/dump byte streams.
interface data_ram_responder_if;
    import cpu_mem_pkg::*;

    logic                  data_w;
    logic [CPU_ADDR_W-1:0] addr;
    logic [BYTE_W-1:0]     din;
    logic [BYTE_W-1:0]     dout;
    logic                  finish;
    logic                  cpu_enable;

    logic                  load_valid;
    logic [BYTE_W-1:0]     load_data;
    logic                  load_last;
    logic                  load_ready;

    logic                  dump_valid;
    logic [BYTE_W-1:0]     dump_data;
    logic                  dump_ready;
    logic                  dump_done;

    logic                  oob_err;

    modport slave (
        input  data_w, addr, din, finish,
        input  load_valid, load_data, load_last,
        input  dump_ready,
        output dout, cpu_enable, load_ready,
        output dump_valid, dump_data, dump_done, oob_err
    );

    modport master (
        output data_w, addr, din, finish,
        output load_valid, load_data, load_last,
        output dump_ready,
        input  dout, cpu_enable, load_ready,
        input  dump_valid, dump_data, dump_done, oob_err
    );

endinterface

// File: rtl/sp_ram_rf.sv
// Single-port byte RAM with a registered, read-first output.
// A write and a read to the same address in one cycle return the old byte.
module sp_ram_rf #(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [7:0]            wdata,
    output logic [7:0]            rdata
);

    logic [7:0] mem [0:(1 << DEPTH_LOG2) - 1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_ram_responder.sv
// Data-side memory for a small CPU: host preloads bytes, the CPU runs against
// the array, then a fixed window is streamed back to the host.
module data_ram_responder
    import cpu_mem_pkg::*;
#(
    parameter int              DEPTH_LOG2 = 12,
    parameter logic [15:0]     DUMP_BASE  = 16'h0000,
    parameter int              DUMP_LEN   = 16
) (
    input  logic                 clk_in,
    input  logic                 reset,
    data_ram_responder_if.slave  bus
);

    localparam logic [DEPTH_LOG2-1:0] BASE_IDX = DUMP_BASE[DEPTH_LOG2-1:0];
    localparam logic [DEPTH_LOG2-1:0] LAST_IDX = DEPTH_LOG2'(DUMP_LEN - 1);

    mem_state_t            state_q;
    mem_state_t            state_d;
    logic [DEPTH_LOG2-1:0] load_ptr_q;
    logic [DEPTH_LOG2-1:0] dump_idx_q;
    logic                  dump_valid_q;
    logic                  rd_ok_q;
    logic                  oob_q;

    logic                  addr_ok;
    logic                  load_fire;
    logic                  dump_fire;
    logic                  cpu_wr;

    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [7:0]            ram_wdata;
    logic [7:0]            ram_rdata;

    assign addr_ok   = addr_in_range(bus.addr, DEPTH_LOG2);
    assign load_fire = reset && (state_q == ST_LOAD) && bus.load_valid;
    assign dump_fire = reset && (state_q == ST_DUMP) && dump_valid_q && bus.dump_ready;
    assign cpu_wr    = reset && (state_q == ST_RUN) && bus.data_w && addr_ok;

    // The single RAM port is owned by whichever phase is active; writes are
    // gated by reset so an abort never lands a stray byte.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = load_ptr_q;
        ram_wdata = bus.load_data;
        unique case (state_q)
            ST_LOAD: begin
                ram_we    = load_fire;
                ram_addr  = load_ptr_q;
                ram_wdata = bus.load_data;
            end
            ST_RUN: begin
                ram_we    = cpu_wr;
                ram_addr  = bus.addr[DEPTH_LOG2-1:0];
                ram_wdata = bus.din;
            end
            ST_DUMP: begin
                ram_addr  = BASE_IDX + dump_idx_q;
            end
            ST_DONE: begin
                ram_addr  = BASE_IDX + dump_idx_q;
            end
            default: begin
                ram_we    = 1'b0;
            end
        endcase
    end

    sp_ram_rf #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk_in),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_LOAD: begin
                if (load_fire && bus.load_last) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.finish) begin
                    state_d = ST_DUMP;
                end
            end
            ST_DUMP: begin
                if (dump_fire && (dump_idx_q == LAST_IDX)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // Dump alternates fetch and present: the RAM re-reads the same byte while
    // the host stalls, so dump_data stays stable without an extra holding register.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            load_ptr_q   <= '0;
            dump_idx_q   <= '0;
            dump_valid_q <= 1'b0;
            rd_ok_q      <= 1'b0;
            oob_q        <= 1'b0;
        end else begin
            if (load_fire) begin
                load_ptr_q <= load_ptr_q + 1'b1;
            end
            if (state_q == ST_DUMP) begin
                if (!dump_valid_q) begin
                    dump_valid_q <= 1'b1;
                end else if (bus.dump_ready) begin
                    dump_valid_q <= 1'b0;
                end
            end else begin
                dump_valid_q <= 1'b0;
            end
            if (dump_fire) begin
                dump_idx_q <= dump_idx_q + 1'b1;
            end
            rd_ok_q <= (state_q == ST_RUN) && addr_ok;
            if ((state_q == ST_RUN) && !addr_ok) begin
                oob_q <= 1'b1;
            end
        end
    end

    assign bus.cpu_enable = reset && (state_q == ST_RUN);
    assign bus.load_ready = reset && (state_q == ST_LOAD);
    assign bus.dump_valid = reset && (state_q == ST_DUMP) && dump_valid_q;
    assign bus.dump_data  = bus.dump_valid ? ram_rdata : 8'h00;
    assign bus.dump_done  = reset && (state_q == ST_DONE);
    assign bus.dout       = (reset && (state_q == ST_RUN) && rd_ok_q) ? ram_rdata : 8'h00;
    assign bus.oob_err    = oob_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// Randomised scoreboard bench for data_ram_responder: a byte-array model predicts
// CPU reads and the dump stream; monitors pop and compare as the DUT responds.
module tb_data_ram_responder;
    import cpu_mem_pkg::*;

    localparam int          DEPTH_LOG2 = 12;
    localparam int          DEPTH      = 1 << DEPTH_LOG2;
    localparam int          DUMP_LEN   = 4;
    localparam logic [15:0] DUMP_BASE  = 16'h0000;

    logic clk_in = 1'b0;
    logic reset  = 1'b0;

    data_ram_responder_if bus ();

    data_ram_responder #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DUMP_BASE  (DUMP_BASE),
        .DUMP_LEN   (DUMP_LEN)
    ) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int          checks_total  = 0;
    int          checks_passed = 0;
    logic [7:0]  model_mem [DEPTH];
    bit          known [DEPTH];
    logic [7:0]  exp_rd [$];
    logic [15:0] exp_rd_addr [$];
    logic [7:0]  exp_dump [$];
    logic [7:0]  load_q [$];
    logic        rd_chk = 1'b0;
    int          dump_hs = 0;
    bit          ready_patt [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        bus.data_w     = 1'b0;
        bus.addr       = 16'h0000;
        bus.din        = 8'h00;
        bus.finish     = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = 8'h00;
        bus.load_last  = 1'b0;
        bus.dump_ready = 1'b0;
        rd_chk         = 1'b0;
    endtask

    // One RUN cycle; the model answers reads from its contents before this cycle's write.
    task automatic apply_stimulus(input logic wr, input logic [15:0] a,
                                  input logic [7:0] d, input bit chk);
        logic in_range;
        next_cycle();
        bus.data_w = wr;
        bus.addr   = a;
        bus.din    = d;
        rd_chk     = chk;
        in_range   = (a >> DEPTH_LOG2) == 16'h0000;
        if (chk) begin
            exp_rd.push_back(in_range ? model_mem[a[DEPTH_LOG2-1:0]] : 8'h00);
            exp_rd_addr.push_back(a);
        end
        if (wr && in_range) begin
            model_mem[a[DEPTH_LOG2-1:0]] = d;
            known[a[DEPTH_LOG2-1:0]]     = 1'b1;
        end
    endtask

    task automatic read_known(input logic [15:0] a);
        apply_stimulus(1'b0, a, 8'h00, known[a[DEPTH_LOG2-1:0]]);
    endtask

    task automatic load_stream();
        int ptr = 0;
        for (int i = 0; i < load_q.size(); i++) begin
            repeat ($urandom_range(0, 2)) begin
                next_cycle();
                bus.load_valid = 1'b0;
            end
            next_cycle();
            bus.load_valid = 1'b1;
            bus.load_data  = load_q[i];
            bus.load_last  = (i == load_q.size() - 1);
            model_mem[ptr] = load_q[i];
            known[ptr]     = 1'b1;
            ptr            = (ptr + 1) % DEPTH;
            @(negedge clk_in);
            check_output($sformatf("load_ready_byte%0d", i), bus.load_ready, 1'b1);
            check_output($sformatf("cpu_enable_before_last%0d", i), bus.cpu_enable, 1'b0);
        end
        next_cycle();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        @(negedge clk_in);
        check_output("cpu_enable_rise", bus.cpu_enable, 1'b1);
        check_output("load_ready_in_run", bus.load_ready, 1'b0);
    endtask

    task automatic start_dump();
        next_cycle();
        bus.data_w = 1'b0;
        bus.addr   = 16'h0000;
        rd_chk     = 1'b0;
        bus.finish = 1'b1;
        for (int i = 0; i < DUMP_LEN; i++) begin
            exp_dump.push_back(model_mem[(int'(DUMP_BASE) + i) % DEPTH]);
        end
    endtask

    task automatic random_run(input int cycles);
        logic [15:0] a;
        logic [7:0]  d;
        logic        wr;
        for (int i = 0; i < cycles; i++) begin
            a  = 16'($urandom_range(0, 47));
            d  = 8'($urandom);
            wr = (a >= 16'd4) && ($urandom_range(0, 1) == 1);
            apply_stimulus(wr, a, d, known[a[DEPTH_LOG2-1:0]]);
        end
    endtask

    initial begin : rd_monitor
        forever begin
            bit chk;
            @(posedge clk_in);
            chk = rd_chk;
            @(negedge clk_in);
            if (chk) begin
                if (exp_rd.size() == 0) begin
                    checks_total++;
                    $display("[TB] FAIL rd_scoreboard: got a read check, expected a queued value");
                end else begin
                    check_output($sformatf("cpu_read@%04h", exp_rd_addr.pop_front()),
                                 bus.dout, exp_rd.pop_front());
                end
            end
        end
    end

    initial begin : dump_monitor
        logic       hold_prev;
        logic [7:0] data_prev;
        hold_prev = 1'b0;
        data_prev = 8'h00;
        forever begin
            @(negedge clk_in);
            if (hold_prev && reset) begin
                check_output("dump_hold_valid", bus.dump_valid, 1'b1);
                check_output("dump_hold_data", bus.dump_data, data_prev);
            end
            if (bus.dump_valid && bus.dump_ready) begin
                if (exp_dump.size() == 0) begin
                    checks_total++;
                    $display("[TB] FAIL dump_extra_byte: got 0x%0h, expected no further byte",
                             bus.dump_data);
                end else begin
                    check_output("dump_data", bus.dump_data, exp_dump.pop_front());
                end
                dump_hs++;
            end
            hold_prev = bus.dump_valid && !bus.dump_ready;
            data_prev = bus.dump_data;
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL global_timeout: got no finish by 200000, expected the run to end");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int n;
        int base;
        bit v1;
        bit v2;
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        check_output("rst_load_ready", bus.load_ready, 1'b0);
        check_output("rst_cpu_enable", bus.cpu_enable, 1'b0);
        check_output("rst_dout", bus.dout, 8'h00);
        check_output("rst_dump_valid", bus.dump_valid, 1'b0);
        check_output("rst_dump_data", bus.dump_data, 8'h00);
        check_output("rst_dump_done", bus.dump_done, 1'b0);
        check_output("rst_oob_err", bus.oob_err, 1'b0);
        next_cycle();
        reset = 1'b1;
        @(negedge clk_in);
        check_output("post_rst_load_ready", bus.load_ready, 1'b1);

        $display("[TB] preload 11,22,33,44 and run");
        load_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        load_stream();
        for (int i = 0; i < 4; i++) read_known(16'(i));
        apply_stimulus(1'b1, 16'h0010, 8'hA5, known[16'h0010]);
        read_known(16'h0010);
        apply_stimulus(1'b1, 16'h0010, 8'h5A, 1'b1);
        read_known(16'h0010);
        random_run(60);
        @(negedge clk_in);
        check_output("oob_clear_in_range", bus.oob_err, 1'b0);

        apply_stimulus(1'b1, 16'h1000, 8'hA7, 1'b1);
        read_known(16'h0000);
        @(negedge clk_in);
        check_output("oob_err_set", bus.oob_err, 1'b1);
        apply_stimulus(1'b0, 16'h1000, 8'h00, 1'b1);
        read_known(16'h0010);

        $display("[TB] dump with stalling host");
        start_dump();
        next_cycle();
        bus.finish     = 1'b0;
        bus.data_w     = 1'b1;
        bus.addr       = 16'h0001;
        bus.din        = 8'hFF;
        bus.load_valid = 1'b1;
        bus.load_data  = 8'h99;
        bus.dump_ready = ready_patt[0];
        @(negedge clk_in);
        check_output("dump_cpu_enable", bus.cpu_enable, 1'b0);
        check_output("dump_dout", bus.dout, 8'h00);
        check_output("dump_load_ready", bus.load_ready, 1'b0);
        v1 = bus.dump_valid;
        v2 = 1'b0;
        n  = 0;
        while (!bus.dump_done && n < 100) begin
            next_cycle();
            n++;
            bus.dump_ready = ready_patt[n % 4];
            if (n == 1) begin
                @(negedge clk_in);
                v2 = bus.dump_valid;
            end
        end
        check_output("dump_valid_latency", v1 | v2, 1'b1);
        check_output("dump_done_reached", bus.dump_done, 1'b1);
        check_output("dump_all_consumed", exp_dump.size(), 0);
        repeat (3) next_cycle();
        @(negedge clk_in);
        check_output("done_dump_valid", bus.dump_valid, 1'b0);
        check_output("done_held", bus.dump_done, 1'b1);
        check_output("oob_err_sticky", bus.oob_err, 1'b1);

        $display("[TB] reset, reload one byte, abort dump after two bytes");
        next_cycle();
        idle_inputs();
        reset = 1'b0;
        @(negedge clk_in);
        check_output("rst2_load_ready", bus.load_ready, 1'b0);
        check_output("rst2_dump_done", bus.dump_done, 1'b0);
        next_cycle();
        reset = 1'b1;
        @(negedge clk_in);
        check_output("rst2_oob_err", bus.oob_err, 1'b0);
        check_output("rst2_load_ready_after", bus.load_ready, 1'b1);
        load_q = '{8'h66};
        load_stream();
        for (int i = 0; i < 4; i++) read_known(16'(i));
        read_known(16'h0010);
        start_dump();
        next_cycle();
        bus.finish     = 1'b0;
        bus.dump_ready = 1'b1;
        base = dump_hs;
        n    = 0;
        while (dump_hs < base + 2 && n < 50) begin
            next_cycle();
            n++;
        end
        check_output("abort_two_bytes", dump_hs - base, 2);
        reset = 1'b0;
        exp_dump.delete();
        @(negedge clk_in);
        check_output("abort_dump_valid", bus.dump_valid, 1'b0);
        check_output("abort_cpu_enable", bus.cpu_enable, 1'b0);
        next_cycle();
        reset          = 1'b1;
        bus.dump_ready = 1'b0;
        @(negedge clk_in);
        check_output("abort_state_load", bus.load_ready, 1'b1);
        check_output("abort_dump_valid_after", bus.dump_valid, 1'b0);
        check_output("abort_dump_done", bus.dump_done, 1'b0);

        // Memory contents survive both resets; only the preload rewrites byte 0.
        load_q = '{8'h77};
        load_stream();
        for (int i = 0; i < 4; i++) read_known(16'(i));
        read_known(16'h0010);
        random_run(20);
        next_cycle();
        idle_inputs();
        next_cycle();
        next_cycle();
        check_output("rd_all_consumed", exp_rd.size(), 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/data_ram_responder.md
DATA_RAM_RESPONDER -- requirements
Module: data_ram_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 12, byte-array address width (4096 bytes).
REQ-002 Parameter DUMP_BASE, default 16'h0000, first address streamed out after finish.
REQ-003 Parameter DUMP_LEN, default 16, number of bytes streamed out after finish (1..2**DEPTH_LOG2).
REQ-004 clk_in  in  1  single clock; all logic samples on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset (0 = reset).
REQ-006 data_w  in  1  CPU data write strobe.
REQ-007 addr  in  16  CPU data address.
REQ-008 din  in  8  CPU write data.
REQ-009 dout  out  8  CPU read data.
REQ-010 finish  in  1  CPU program-complete flag.
REQ-011 cpu_enable  out  1  drives CPU enable; high only in RUN.
REQ-012 load_valid / load_data[7:0] / load_last  in  1/8/1  host preload byte stream.
REQ-013 load_ready  out  1  preload byte accepted when load_valid and load_ready are both 1.
REQ-014 dump_valid / dump_data[7:0]  out  1/8  result byte stream.
REQ-015 dump_ready  in  1  dump byte consumed when dump_valid and dump_ready are both 1.
REQ-016 dump_done  out  1  all DUMP_LEN bytes consumed.
REQ-017 oob_err  out  1  sticky out-of-range CPU access flag.

Function
REQ-018 FSM states: LOAD, RUN, DUMP, DONE; LOAD is entered on reset.
REQ-019 LOAD: load_ready=1; each accepted byte is written at load_ptr, and load_ptr increments, wrapping from 2**DEPTH_LOG2-1 to 0.
REQ-020 LOAD: an accepted byte with load_last=1 is written, then the FSM moves to RUN on the next cycle.
REQ-021 RUN: cpu_enable=1; data_w=1 with in-range addr writes din to mem[addr] at that edge.
REQ-022 Read latency is 1 cycle: dout = mem[addr sampled at the previous edge].
REQ-023 Read-during-write to the same address returns the old byte (read-first).
REQ-024 In range means addr[15:DEPTH_LOG2]==0.
REQ-025 Out-of-range access: the write is dropped, the read returns 8'h00, and oob_err sets and stays set until reset.
REQ-026 data_w is ignored in every state except RUN.
REQ-027 dout holds 8'h00 outside RUN.
REQ-028 RUN with finish=1 sampled: move to DUMP next cycle; cpu_enable drops in the same cycle the state becomes DUMP.
REQ-029 DUMP: stream bytes mem[DUMP_BASE+i] for i=0..DUMP_LEN-1, with the address wrapping modulo the depth.
REQ-030 DUMP: dump_valid first asserts no later than the 2nd cycle in DUMP.
REQ-031 DUMP: dump_data and dump_valid are held stable while dump_valid=1 and dump_ready=0.
REQ-032 DUMP throughput is at least one byte per 2 cycles while dump_ready=1.
REQ-033 After byte DUMP_LEN-1 is accepted, the FSM enters DONE: dump_valid=0, dump_done=1; DONE is held until reset.
REQ-034 load_ready=0 outside LOAD; load_valid is ignored outside LOAD.
REQ-035 finish is ignored outside RUN.

Reset
REQ-036 With reset=0 at an edge, state goes to LOAD and load_ptr and the dump index clear to 0.
REQ-037 Reset output values: cpu_enable=0, dout=0, load_ready=0 during the reset cycle and 1 after it, dump_valid=0, dump_data=0, dump_done=0, oob_err=0.
REQ-038 Memory contents are not cleared by reset.
REQ-039 Reset asserted mid-LOAD, mid-RUN or mid-DUMP aborts the operation within that cycle, with no further writes.

Structure
REQ-040 State encoding and the LOAD/RUN/DUMP/DONE constants belong in shared package cpu_mem_pkg, reused by the instruction-side loader.
REQ-041 The byte array is one sub-module, sp_ram_rf: single-port, synchronous read-first, parameterised by DEPTH_LOG2.
REQ-042 The FSM, the pointers and the address-range check stay in data_ram_responder.

Verification
REQ-043 Bench shall cover: preload 4 bytes 11,22,33,44 (last on 44) -> mem[0..3]=11,22,33,44; cpu_enable rises 1 cycle after the 44 handshake.
REQ-044 Bench shall cover: RUN, write 8'hA5 to 16'h0010, then read 16'h0010 -> dout=A5 one cycle after addr is applied.
REQ-045 Bench shall cover: same-cycle write 8'h5A and read of 16'h0010 holding A5 -> dout=A5, then 5A on the following read.
REQ-046 Bench shall cover: write to 16'h1000 -> mem unchanged, read returns 00, oob_err=1 until reset.
REQ-047 Bench shall cover: finish=1 with DUMP_LEN=4, and dump_ready toggled 1,0,0,1,... -> stream 11,22,33,44 with no drop or duplicate, then dump_done=1.
REQ-048 Bench shall cover: reset=0 after 2 dump bytes -> next cycle state LOAD, dump_valid=0, and mem[0]=11 preserved.
